// File: rtl/spi_slave_burst_scheduler.sv
// ============================================================================
// Module   : spi_slave_burst_scheduler
// Function : Splits one SPI transfer into AXI INCR bursts (cap + 4 KB rule),
//            limits bursts in flight and reports done/error/abort status.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module spi_slave_burst_scheduler #(
    parameter int AXI_ADDR_WIDTH  = 32,
    parameter int MAX_BURST_WORDS = 16,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                      axi_aclk,
    input  logic                      axi_areset,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic                      cmd_rd_wr,
    input  logic [AXI_ADDR_WIDTH-1:0] cmd_addr,
    input  logic [15:0]               cmd_words,
    input  logic                      abort,
    output logic                      bst_valid,
    input  logic                      bst_ready,
    output logic                      bst_rd_wr,
    output logic [AXI_ADDR_WIDTH-1:0] bst_addr,
    output logic [7:0]                bst_len,
    output logic                      bst_last,
    input  logic                      rsp_valid,
    input  logic                      rsp_err,
    output logic                      done,
    output logic                      done_err,
    output logic                      done_abort
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    localparam logic [16:0]               C_MAX_BEATS = 17'(MAX_BURST_WORDS);
    localparam logic [3:0]                C_MAX_OUT   = 4'(MAX_OUTSTANDING);
    localparam logic [AXI_ADDR_WIDTH-1:0] C_WORD_MASK = ~AXI_ADDR_WIDTH'(3);

    state_t                    state_q, state_d;
    logic [AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [15:0]               remaining_q, remaining_d;
    logic                      rd_wr_q, rd_wr_d;
    logic [3:0]                outstanding_q, outstanding_d;
    logic                      err_q, err_d;
    logic                      abort_flag_q, abort_flag_d;
    logic                      cmd_ready_q, cmd_ready_d;
    logic                      bst_valid_q, bst_valid_d;
    logic [AXI_ADDR_WIDTH-1:0] bst_addr_q, bst_addr_d;
    logic [7:0]                bst_len_q, bst_len_d;
    logic                      bst_rd_wr_q, bst_rd_wr_d;
    logic                      bst_last_q, bst_last_d;
    logic                      done_q, done_d;
    logic                      done_err_q, done_err_d;
    logic                      done_abort_q, done_abort_d;

    logic                      cmd_fire, bst_fire, rsp_count, issue_d;
    logic [16:0]               cur_beats, nxt_beats;

    // Beats = min(remaining, cap, words left before the next 4 KB page).
    function automatic logic [16:0] beats_f(input logic [11:0] offs, input logic [15:0] rem);
        logic [12:0] room;
        logic [16:0] b;
        room = (13'd4096 - {1'b0, offs}) >> 2;
        b    = {1'b0, rem};
        if (b > C_MAX_BEATS)    b = C_MAX_BEATS;
        if (b > {4'b0, room})   b = {4'b0, room};
        return b;
    endfunction

    always_comb begin
        cmd_fire  = cmd_ready_q && cmd_valid;
        bst_fire  = bst_valid_q && bst_ready;
        rsp_count = rsp_valid && (outstanding_q != 4'd0);
        cur_beats = beats_f(addr_q[11:0], remaining_q);

        state_d       = state_q;
        addr_d        = addr_q;
        remaining_d   = remaining_q;
        rd_wr_d       = rd_wr_q;
        err_d         = err_q | (rsp_count & rsp_err);
        abort_flag_d  = abort_flag_q;
        outstanding_d = outstanding_q + {3'b0, bst_fire} - {3'b0, rsp_count};
        done_d        = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (cmd_fire) begin
                    addr_d       = cmd_addr & C_WORD_MASK;
                    rd_wr_d      = cmd_rd_wr;
                    remaining_d  = cmd_words;
                    err_d        = 1'b0;
                    abort_flag_d = 1'b0;
                    state_d      = (cmd_words == 16'd0) ? S_DRAIN : S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (bst_fire) begin
                    addr_d      = addr_q + AXI_ADDR_WIDTH'({cur_beats, 2'b00});
                    remaining_d = remaining_q - cur_beats[15:0];
                    // Once the final burst is accepted an abort no longer matters.
                    if (bst_last_q) begin
                        state_d = S_DRAIN;
                    end else if (abort) begin
                        abort_flag_d = 1'b1;
                        state_d      = S_DRAIN;
                    end
                end else if (abort) begin
                    abort_flag_d = 1'b1;
                    state_d      = S_DRAIN;
                end
            end
            S_DRAIN: begin
                state_d = S_DRAIN;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Finishing drain is folded into the transition so done appears one cycle early.
        if ((state_d == S_DRAIN) && (outstanding_d == 4'd0)) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
        end

        issue_d      = (state_d == S_ISSUE);
        nxt_beats    = beats_f(addr_d[11:0], remaining_d);
        cmd_ready_d  = (state_d == S_IDLE);
        bst_valid_d  = issue_d && (outstanding_d < C_MAX_OUT);
        bst_addr_d   = issue_d ? addr_d : '0;
        bst_len_d    = issue_d ? 8'(nxt_beats - 17'd1) : 8'd0;
        bst_last_d   = issue_d && (nxt_beats == {1'b0, remaining_d});
        bst_rd_wr_d  = issue_d && rd_wr_d;
        done_err_d   = done_d & err_d;
        done_abort_d = done_d & abort_flag_d;
    end

    always_ff @(posedge axi_aclk) begin
        if (axi_areset) begin
            state_q       <= S_IDLE;
            addr_q        <= '0;
            remaining_q   <= 16'd0;
            rd_wr_q       <= 1'b0;
            outstanding_q <= 4'd0;
            err_q         <= 1'b0;
            abort_flag_q  <= 1'b0;
            cmd_ready_q   <= 1'b0;
            bst_valid_q   <= 1'b0;
            bst_addr_q    <= '0;
            bst_len_q     <= 8'd0;
            bst_rd_wr_q   <= 1'b0;
            bst_last_q    <= 1'b0;
            done_q        <= 1'b0;
            done_err_q    <= 1'b0;
            done_abort_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            remaining_q   <= remaining_d;
            rd_wr_q       <= rd_wr_d;
            outstanding_q <= outstanding_d;
            err_q         <= err_d;
            abort_flag_q  <= abort_flag_d;
            cmd_ready_q   <= cmd_ready_d;
            bst_valid_q   <= bst_valid_d;
            bst_addr_q    <= bst_addr_d;
            bst_len_q     <= bst_len_d;
            bst_rd_wr_q   <= bst_rd_wr_d;
            bst_last_q    <= bst_last_d;
            done_q        <= done_d;
            done_err_q    <= done_err_d;
            done_abort_q  <= done_abort_d;
        end
    end

    assign cmd_ready  = cmd_ready_q;
    assign bst_valid  = bst_valid_q;
    assign bst_addr   = bst_addr_q;
    assign bst_len    = bst_len_q;
    assign bst_rd_wr  = bst_rd_wr_q;
    assign bst_last   = bst_last_q;
    assign done       = done_q;
    assign done_err   = done_err_q;
    assign done_abort = done_abort_q;

endmodule

`default_nettype wire

// File: doc/spi_slave_burst_scheduler.md
Name: spi_slave_burst_scheduler

Overview:
- Sits between the SPI slave controller's address/command path and the AXI plug.
- Splits one SPI-issued transfer (start address plus word count) into legal AXI INCR bursts. Each burst is capped at MAX_BURST_WORDS and never crosses a 4 KB boundary.
- Limits in-flight bursts to MAX_OUTSTANDING and reports completion, error and abort status back to the SPI side.

Parameters:
- AXI_ADDR_WIDTH, 32, width of the command and burst addresses.
- MAX_BURST_WORDS, 16, maximum 32-bit beats per burst (1..256, power of two).
- MAX_OUTSTANDING, 4, maximum bursts issued but not yet completed (1..15).

Ports:
- axi_aclk  in  1  sole clock for all logic.
- axi_areset  in  1  reset; synchronous, active-high.
- cmd_valid  in  1  transfer request valid.
- cmd_ready  out  1  scheduler can accept a request.
- cmd_rd_wr  in  1  1 = read, 0 = write.
- cmd_addr  in  AXI_ADDR_WIDTH  start byte address; bits [1:0] ignored and treated as 0.
- cmd_words  in  16  number of 32-bit words to transfer.
- abort  in  1  synchronised chip-select release; stops further burst issue.
- bst_valid  out  1  burst descriptor valid.
- bst_ready  in  1  AXI plug accepted the descriptor (AW/AR issued).
- bst_rd_wr  out  1  direction of the current burst.
- bst_addr  out  AXI_ADDR_WIDTH  burst start address, word aligned.
- bst_len  out  8  AXI len encoding (beats - 1).
- bst_last  out  1  this is the final burst of the transfer.
- rsp_valid  in  1  one pulse per completed burst (B handshake, or R with rlast).
- rsp_err  in  1  completion carried SLVERR/DECERR; qualified by rsp_valid.
- done  out  1  one-cycle pulse: transfer finished and fully drained.
- done_err  out  1  sticky error for the transfer; valid with done.
- done_abort  out  1  transfer was cut short by abort; valid with done.

Behaviour:
- Reset (axi_areset high at a clock edge) forces all of the following, abandoning any transfer in progress:
  - State goes to IDLE.
  - cmd_ready=0 while reset is asserted, then 1 on the first cycle after reset.
  - bst_valid=0; bst_addr, bst_len, bst_rd_wr and bst_last are 0.
  - done, done_err and done_abort are 0.
  - The outstanding counter is cleared.
- States:
  - IDLE: cmd_ready=1.
    - On cmd_valid&cmd_ready, latch addr (word aligned), rd_wr and remaining=cmd_words; clear the err and abort flags.
    - If cmd_words==0, go to DRAIN; done pulses on the next cycle with no burst issued.
    - Otherwise go to ISSUE. bst_valid can rise no earlier than the cycle after the command handshake.
  - ISSUE: cmd_ready=0.
    - beats = min(remaining, MAX_BURST_WORDS, (4096 - addr[11:0]) >> 2).
    - Boundary arithmetic uses 13-bit unsigned values; 4096 at addr[11:0]==0 must not truncate.
    - bst_len = beats - 1; bst_last = (beats == remaining).
    - bst_valid = (outstanding < MAX_OUTSTANDING) && !abort.
    - Once bst_valid is high, the descriptor stays stable until bst_ready.
    - On bst_valid&bst_ready: addr += beats*4 (modulo 2^AXI_ADDR_WIDTH), remaining -= beats, outstanding++. If bst_last, go to DRAIN.
    - If abort is seen while bst_valid is low, or while high but not yet accepted: drop that descriptor, set the abort flag, go to DRAIN.
  - DRAIN: cmd_ready=0, bst_valid=0.
    - When outstanding==0, assert done for one cycle with done_err and done_abort, then go to IDLE.
- Outstanding counter:
  - Increments on burst accept, decrements on rsp_valid.
  - Burst accept and rsp_valid in the same cycle leave it unchanged.
  - rsp_valid while outstanding==0 is ignored (no underflow).
- Error flag: rsp_err with rsp_valid sets the sticky flag for the current transfer. It is cleared only on a new command accept or reset.
- abort in IDLE is ignored.
- An abort after bst_last has been accepted has no effect; done_abort stays 0.
- done pulses exactly once per accepted command.

Test Plan:
- Split at burst cap: cmd addr 0x1000_0000, words 40, bst_ready=1, rsp one cycle after each accept.
  - Required bursts: (0x1000_0000, len 15), (0x1000_0040, len 15), (0x1000_0080, len 7, last=1).
  - Required done: one pulse after the third rsp, err=0.
- 4 KB boundary: cmd addr 0x0000_0FF0, words 8.
  - Required bursts: (0x0FF0, len 3), (0x1000, len 3, last=1).
  - addr 0x0000_0FFE is treated as 0x0FFC, giving a first burst of len 0.
- Outstanding limit: words 100, bst_ready=1, no rsp.
  - Exactly 4 bursts issued, then bst_valid held low.
  - One rsp_valid lets exactly one more burst issue.
  - A same-cycle accept plus rsp keeps the counter at 4.
- Zero length: cmd words 0 -> no bst_valid; done pulses the cycle after the handshake; err=0, abort=0.
- Abort and error: words 64; rsp_err=1 on the first rsp; abort asserted after 2 bursts are accepted.
  - No further bst_valid; done after 2 rsps with done_err=1, done_abort=1.
  - The next command starts with both flags clear.
- Reset mid-transfer: axi_areset for 1 cycle while in ISSUE with outstanding=3.
  - All outputs return to reset values; cmd_ready=1 on the following cycle.
  - Stale rsp_valid pulses afterwards are ignored and cause no counter underflow.
